// File: rtl/cal_pkg.sv
// Shared encodings for the two-client calculator scheduler: ALU op codes,
// sequencer states, register-file addresses and write-mux selects.
package cal_pkg;

    // ALU operation codes as presented on the DP 'c' lines
    typedef enum logic [1:0] {
        OP_XOR = 2'b00,
        OP_AND = 2'b01,
        OP_SUB = 2'b10,
        OP_ADD = 2'b11
    } op_e;

    // Sequencer states; the numeric value is exported on cso for debug
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LD1  = 4'd1,
        S_LD2  = 4'd2,
        S_EXE  = 4'd3,
        S_RD   = 4'd4,
        S_DONE = 4'd5
    } state_e;

    // Register-file addresses used by the fixed load/load/execute/read sequence
    localparam logic [1:0] REG_R1 = 2'b01;
    localparam logic [1:0] REG_R2 = 2'b10;
    localparam logic [1:0] REG_R3 = 2'b11;

    // Write-data mux selects
    localparam logic [1:0] SEL1_ALU = 2'b00;
    localparam logic [1:0] SEL1_IN2 = 2'b10;
    localparam logic [1:0] SEL1_IN1 = 2'b11;

endpackage

// File: rtl/cal_sched_if.sv
// Client-side bus of the scheduler: two level requesters with operands,
// their ack pulses, and the tagged result return.
interface cal_sched_if #(
    parameter int W = 3
);
    logic         req0;
    logic         req1;
    logic [1:0]   op0;
    logic [1:0]   op1;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         ack0;
    logic         ack1;
    logic         res_valid;
    logic         res_id;
    logic [W-1:0] res_data;

    // Clients drive requests and operands, consume acks and results
    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1,
        input  ack0, ack1, res_valid, res_id, res_data
    );

    // Scheduler side
    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1,
        output ack0, ack1, res_valid, res_id, res_data
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. A lone requester always wins; on contention
// the side named by the pointer wins. Each accepted grant moves the pointer
// to the side that lost.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       ptr
);

    // Grant selection: one-hot, pointer only matters when both request
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer update: after a grant, favour the requester that did not win
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/cal_sched.sv
// Two-requester scheduler/sequencer for the shared 3-bit calculator datapath.
// Grants one client at a time, walks the DP through load R1, load R2,
// execute into R3 and read-out, then returns the result tagged with the
// requester ID. One operation every six cycles at best.
module cal_sched
    import cal_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         CLK,
    input  logic         RST,
    cal_sched_if.slave   bus,
    output logic         busy,
    output logic [3:0]   cso,
    output logic [W-1:0] in1,
    output logic [W-1:0] in2,
    output logic [1:0]   sel1,
    output logic         sel2,
    output logic [1:0]   c,
    output logic [1:0]   WA,
    output logic         WE,
    output logic [1:0]   RAA,
    output logic [1:0]   RAB,
    output logic         REA,
    output logic         REB,
    input  logic [W-1:0] out
);

    state_e       state_q;
    state_e       state_d;
    logic [1:0]   req;
    logic [1:0]   gnt;
    logic         arb_ptr;
    logic         take;
    logic         id_q;
    logic [1:0]   op_q;
    logic [W-1:0] res_q;

    assign req = {bus.req1, bus.req0};

    rr_arb2 u_arb (
        .clk     (CLK),
        .rst     (RST),
        .req     (req),
        .advance (take),
        .gnt     (gnt),
        .ptr     (arb_ptr)
    );

    // A grant is only taken in IDLE; reset masks it so acks stay low while
    // reset is held even if a client keeps requesting.
    assign take     = (state_q == S_IDLE) && !RST && (gnt != 2'b00);
    assign bus.ack0 = take && gnt[0];
    assign bus.ack1 = take && gnt[1];

    assign bus.res_valid = (state_q == S_DONE);
    assign bus.res_id    = (state_q == S_DONE) ? id_q : 1'b0;
    assign bus.res_data  = res_q;

    assign busy = (state_q != S_IDLE);
    assign cso  = state_q;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and DP control lines; anything not driven in a state is 0
    always_comb begin
        state_d = state_q;
        sel1    = SEL1_ALU;
        sel2    = 1'b0;
        c       = 2'b00;
        WA      = 2'b00;
        WE      = 1'b0;
        RAA     = 2'b00;
        RAB     = 2'b00;
        REA     = 1'b0;
        REB     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (take) begin
                    state_d = S_LD1;
                end
            end
            S_LD1: begin
                sel1    = SEL1_IN1;
                WA      = REG_R1;
                WE      = 1'b1;
                state_d = S_LD2;
            end
            S_LD2: begin
                sel1    = SEL1_IN2;
                WA      = REG_R2;
                WE      = 1'b1;
                state_d = S_EXE;
            end
            S_EXE: begin
                RAA     = REG_R1;
                RAB     = REG_R2;
                REA     = 1'b1;
                REB     = 1'b1;
                c       = op_q;
                sel1    = SEL1_ALU;
                WA      = REG_R3;
                WE      = 1'b1;
                state_d = S_RD;
            end
            S_RD: begin
                // R3 AND R3 passes R3 through the ALU onto the output gate
                RAA     = REG_R3;
                RAB     = REG_R3;
                REA     = 1'b1;
                REB     = 1'b1;
                c       = OP_AND;
                sel2    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Capture the winner's op, operands and ID in the grant cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            id_q <= 1'b0;
            op_q <= 2'b00;
            in1  <= '0;
            in2  <= '0;
        end else if (take) begin
            id_q <= gnt[1];
            op_q <= gnt[1] ? bus.op1 : bus.op0;
            in1  <= gnt[1] ? bus.a1 : bus.a0;
            in2  <= gnt[1] ? bus.b1 : bus.b0;
        end
    end

    // Result register: samples the gated DP output during read-out and
    // holds it until the next read-out
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            res_q <= '0;
        end else if (state_q == S_RD) begin
            res_q <= out;
        end
    end

    // Contested grants follow the pointer, and the two acks never overlap
    a_contest_ptr : assert property (@(posedge CLK) disable iff (RST)
        (take && req == 2'b11) |-> (gnt[1] == arb_ptr));
    a_ack_onehot : assert property (@(posedge CLK) disable iff (RST)
        !(bus.ack0 && bus.ack1));
    a_ack_idle_only : assert property (@(posedge CLK) disable iff (RST)
        (bus.ack0 || bus.ack1) |-> (state_q == S_IDLE));

endmodule

// File: doc/cal_sched.md
# cal_sched

Two-requester scheduler and sequencer for the 3-bit calculator datapath (DP: 4-entry register file, 2-bit-op ALU, write-data mux, output gate). It accepts operation requests from two clients and arbitrates round-robin. It runs each granted operation as a fixed load/load/execute/read-out sequence on DP control lines and returns the result tagged with the requester ID. It replaces the single-client FSM when the DP is shared.

## Interface
Parameters:
- W, 3, operand/result width (DP word width)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- req0, req1  in  1  level request; held until ackN
- op0, op1  in  2  operation: 11 add, 10 sub, 01 and, 00 xor
- a0, b0, a1, b1  in  W  operands
- ack0, ack1  out  1  one-cycle pulse; operands/op captured that cycle
- res_valid  out  1  one-cycle pulse, result valid
- res_id  out  1  requester of res_data
- res_data  out  W  result
- busy  out  1  high in every state except IDLE
- cso  out  4  current state encoding (debug)
- in1, in2  out  W  DP operand inputs (captured a, b)
- sel1  out  2  DP write mux: 11 in1, 10 in2, 00 ALU
- sel2  out  1  DP output gate: 1 drives ALU result onto out
- c  out  2  DP ALU op
- WA  out  2  write address
- WE  out  1  write enable
- RAA, RAB  out  2  read addresses
- REA, REB  out  1  read enables
- out  in  W  DP output

## Operation
- States: IDLE(0), LD1(1), LD2(2), EXE(3), RD(4), DONE(5).
- IDLE: if any req, grant per round-robin pointer. Assert ack of the winner. Latch op, a, b, id. Go to LD1.
- LD1: sel1=11, WA=01, WE=1 (R1←in1).
- LD2: sel1=10, WA=10, WE=1 (R2←in2).
- EXE: RAA=01, RAB=10, REA=REB=1, c=latched op, sel1=00, WA=11, WE=1 (R3←R1 op R2).
- RD: RAA=RAB=11, REA=REB=1, c=01, sel2=1. Register `out` into res_data at the end of the cycle.
- DONE: res_valid=1, res_id=latched id. Go to IDLE.
- DP control outputs not listed for a state are 0.
- Arithmetic is modulo 2^W. Sub is a−b in two's complement. No carry/borrow output.
- Round-robin: pointer starts at 0 and toggles to the non-winner after each grant. If both requesters assert, the pointer side wins. A single requester always wins regardless of the pointer.
- Requests arriving in non-IDLE states wait. A req dropped before ack is ignored.

## Timing
- Grant/ack in cycle N (IDLE). LD1 N+1, LD2 N+2, EXE N+3, RD N+4, res_valid N+5.
- Back-to-back: next ack earliest N+6. Throughput is one op per 6 cycles.
- res_data holds its value until the next RD cycle.
- Reset values: state IDLE, pointer 0. All outputs 0, including res_data, in1, in2 and cso.
- RST mid-operation: immediate return to IDLE. The in-flight op is dropped with no res_valid. The requester has already been acked and must reissue.
- Exactly one ack per IDLE→LD1 transition. ack0 and ack1 are never high together.

## Structure
- Package cal_pkg:
  - op codes (OP_ADD=11, OP_SUB=10, OP_AND=01, OP_XOR=00)
  - state encodings
  - register addresses (R1=01, R2=10, R3=11)
  - sel1 encodings
- Sub-module rr_arb2: 2-input round-robin arbiter.
  - Inputs: req[1:0], advance (pulse on grant).
  - Output: one-hot gnt plus pointer.
  - Async active-high reset.
- The top module holds the sequencing FSM and the capture registers. Verification instantiates the top module with the existing DP.

## Test plan
- Single requester, all ops (RST released, req0 held, a0=110, b0=010):
  - op0=11 → res_data=000
  - op0=10 → 100
  - op0=01 → 010
  - op0=00 → 100
  - Each with res_id=0 and res_valid exactly 5 cycles after ack0.
- Contention: req0 and req1 both asserted from reset.
  - Order is ack0, then ack1 6 cycles later, then ack0.
  - Results are tagged res_id 0, 1, 0.
  - Uses op1=11, a1=111, b1=001 → res_data=000.
- Wrap/borrow: op=10, a=000, b=001 → 111. op=11, a=111, b=111 → 110.
- Reset mid-op: assert RST during EXE.
  - All outputs go to 0 immediately.
  - No res_valid occurs.
  - After release, pointer=0: req1 alone is granted on the first IDLE cycle.
- Late/dropped request: req1 pulses for one cycle while busy → no ack1 and no result. req1 asserted 1 cycle before DONE → ack1 in the following IDLE cycle.
- Control check: per state, compare WA/WE/sel1/sel2/c/RAA/RAB/REA/REB and cso against the values in Operation.
